// File: rtl/led_matrix_bcm_decode.sv
// BCM bit-plane decoder: counts on-frames per pixel over one BCM cycle
// and emits the reconstructed colour of every pixel pair.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   frame_sync, image_sync   frame boundary / last-frame-of-cycle marker
//   pix_valid                one pixel pair on matrix_rgb_upper/lower ({B,G,R})
//   dec_valid, dec_addr      decoded pixel pair strobe and index
//   dec_rgb_upper/lower      3 channels, channel i at [i*COLOR_DEPTH +: COLOR_DEPTH]
//   dec_frame_done           pulse after the last decoded pixel of an image
//   sync_err, pix_err        misalignment / overflow or phase-0 bit pulses
module led_matrix_bcm_decode #(
  parameter int COLOR_DEPTH = 8,
  parameter int NUM_PIXELS  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_sync,
  input  logic                         image_sync,
  input  logic                         pix_valid,
  input  logic [2:0]                   matrix_rgb_upper,
  input  logic [2:0]                   matrix_rgb_lower,
  output logic                         dec_valid,
  output logic [$clog2(NUM_PIXELS)-1:0] dec_addr,
  output logic [3*COLOR_DEPTH-1:0]     dec_rgb_upper,
  output logic [3*COLOR_DEPTH-1:0]     dec_rgb_lower,
  output logic                         dec_frame_done,
  output logic                         sync_err,
  output logic                         pix_err
);

  localparam int D  = COLOR_DEPTH;
  localparam int AW = $clog2(NUM_PIXELS);
  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam int RW = 6 * D;

  logic [D-1:0]  phase;
  logic [D-1:0]  phase_nxt;
  logic          locked;
  logic          locked_nxt;
  logic [CW-1:0] pix_cnt;
  logic [CW-1:0] cnt_eff;

  logic sync_err_nxt;
  logic done_arm;
  logic done_pend;
  logic done_fire;
  logic accept;
  logic overflow;
  logic bit_err;

  // stage A: address issued to the accumulator RAM
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [5:0]    a_bits;
  logic          a_clr;
  logic          a_emit;

  // stage B: accumulator read back, update and write
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [5:0]    b_bits;
  logic          b_clr;
  logic          b_emit;
  logic [RW-1:0] b_acc;
  logic [RW-1:0] wdata;

  logic [RW-1:0] acc_ram [NUM_PIXELS];

  // Frame sync takes effect before a pixel in the same cycle.
  always_comb begin
    phase_nxt    = phase;
    locked_nxt   = locked;
    sync_err_nxt = 1'b0;
    done_arm     = 1'b0;
    if (frame_sync) begin
      phase_nxt = phase + 1'b1;
      if (image_sync) begin
        phase_nxt  = '0;
        locked_nxt = 1'b1;
        if (&phase) begin
          done_arm = locked;
        end else begin
          sync_err_nxt = locked;
        end
      end else if (&phase) begin
        sync_err_nxt = locked;
        locked_nxt   = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_eff  = frame_sync ? '0 : pix_cnt;
    accept   = pix_valid && (cnt_eff < CW'(NUM_PIXELS));
    overflow = pix_valid && !(cnt_eff < CW'(NUM_PIXELS));
    bit_err  = accept && (phase_nxt == '0)
             && (|{matrix_rgb_lower, matrix_rgb_upper});
  end

  // Phase 0 restarts the count, every other phase adds its bit.
  always_comb begin
    wdata = '0;
    for (int c = 0; c < 6; c++) begin
      if (b_clr) begin
        wdata[c*D +: D] = D'(b_bits[c]);
      end else begin
        wdata[c*D +: D] = b_acc[c*D +: D] + D'(b_bits[c]);
      end
    end
  end

  // Wait for every pixel of the emitted image to leave the pipe.
  assign done_fire = done_pend
                   && !(a_valid && a_emit)
                   && !(b_valid && b_emit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      locked   <= 1'b0;
      pix_cnt  <= '0;
      sync_err <= 1'b0;
      pix_err  <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      locked   <= locked_nxt;
      pix_cnt  <= cnt_eff + CW'(accept);
      sync_err <= sync_err_nxt;
      pix_err  <= overflow | bit_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_bits  <= '0;
      a_clr   <= 1'b0;
      a_emit  <= 1'b0;
      b_valid <= 1'b0;
      b_addr  <= '0;
      b_bits  <= '0;
      b_clr   <= 1'b0;
      b_emit  <= 1'b0;
    end else begin
      a_valid <= accept;
      a_addr  <= cnt_eff[AW-1:0];
      a_bits  <= {matrix_rgb_lower, matrix_rgb_upper};
      a_clr   <= phase_nxt == '0;
      a_emit  <= locked_nxt && (&phase_nxt);
      b_valid <= a_valid;
      b_addr  <= a_addr;
      b_bits  <= a_bits;
      b_clr   <= a_clr;
      b_emit  <= a_emit;
    end
  end

  // Same-address back-to-back pixels (one-pixel frame) forward the write.
  always_ff @(posedge clk) begin
    if (b_valid) begin
      acc_ram[b_addr] <= wdata;
    end
    if (b_valid && (b_addr == a_addr)) begin
      b_acc <= wdata;
    end else begin
      b_acc <= acc_ram[a_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid      <= 1'b0;
      dec_addr       <= '0;
      dec_rgb_upper  <= '0;
      dec_rgb_lower  <= '0;
      dec_frame_done <= 1'b0;
      done_pend      <= 1'b0;
    end else begin
      dec_valid      <= b_valid && b_emit;
      dec_frame_done <= done_fire;
      if (b_valid && b_emit) begin
        dec_addr      <= b_addr;
        dec_rgb_upper <= wdata[3*D-1:0];
        dec_rgb_lower <= wdata[RW-1:3*D];
      end
      if (done_arm) begin
        done_pend <= 1'b1;
      end else if (done_fire) begin
        done_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_bcm_decode.sv
// Bench for led_matrix_bcm_decode: BCM-encoded loopback with an
// on-frame counting reference model and scenario checks.
module tb_led_matrix_bcm_decode;

  localparam int D = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_sync;
  logic        image_sync;
  logic        pix_valid;
  logic [2:0]  up_b;
  logic [2:0]  lo_b;
  logic        dec_valid;
  logic [1:0]  dec_addr;
  logic [11:0] dec_rgb_upper;
  logic [11:0] dec_rgb_lower;
  logic        dec_frame_done;
  logic        sync_err;
  logic        pix_err;

  led_matrix_bcm_decode #(
    .COLOR_DEPTH(D),
    .NUM_PIXELS(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_sync(frame_sync),
    .image_sync(image_sync),
    .pix_valid(pix_valid),
    .matrix_rgb_upper(up_b),
    .matrix_rgb_lower(lo_b),
    .dec_valid(dec_valid),
    .dec_addr(dec_addr),
    .dec_rgb_upper(dec_rgb_upper),
    .dec_rgb_lower(dec_rgb_lower),
    .dec_frame_done(dec_frame_done),
    .sync_err(sync_err),
    .pix_err(pix_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][11:0] up;
    logic [3:0][11:0] lo;
    logic [3:0][11:0] eu;
    logic [3:0][11:0] el;
  } vec_t;

  typedef struct packed {
    int          cyc;
    int          addr;
    logic [11:0] u;
    logic [11:0] l;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   dv_cnt = 0;
  int   done_cnt = 0;
  int   serr_cnt = 0;
  int   perr_cnt = 0;
  int   last_dv = 0;
  int   done_cyc = 0;
  exp_t expq[$];

  logic [11:0] col_up [N];
  logic [11:0] col_lo [N];
  logic [11:0] cap_up [N];
  logic [11:0] cap_lo [N];
  int          cnt_u [N][3];
  int          cnt_l [N][3];
  bit          inj_p1 = 1'b0;
  int          ovf_phase = -1;
  vec_t        tbl [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dec_valid) begin
        exp_t e;
        dv_cnt++;
        last_dv = cyc;
        cap_up[dec_addr] = dec_rgb_upper;
        cap_lo[dec_addr] = dec_rgb_lower;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_dec_valid: got addr %0d expected none",
                   dec_addr);
        end else begin
          e = expq.pop_front();
          chk("dv_latency", cyc, e.cyc);
          chk("dv_addr", int'(dec_addr), e.addr);
          chk("dv_upper", int'(dec_rgb_upper), int'(e.u));
          chk("dv_lower", int'(dec_rgb_lower), int'(e.l));
        end
      end
      if (dec_frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (sync_err) serr_cnt++;
      if (pix_err) perr_cnt++;
    end
  end

  // BCM encoder: phase p>0 shows bit floor(log2 p), phase 0 is dark.
  function automatic logic [2:0] enc(input logic [11:0] c, input int p);
    int k;
    logic [2:0] r;
    r = 3'b000;
    if (p != 0) begin
      k = 0;
      for (int j = 0; j < D; j++) if (p >= (1 << j)) k = j;
      r = {c[8 + k], c[4 + k], c[k]};
    end
    return r;
  endfunction

  function automatic logic [11:0] pack3(input int a, input int b, input int c);
    return {4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic send_frame(input int p, input bit isync, input bit emit);
    int np;
    np = (p == ovf_phase) ? N + 1 : N;
    for (int i = 0; i < np; i++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      pix_valid = 1'b1;
      if (i < N) begin
        up_b = enc(col_up[i], p);
        lo_b = enc(col_lo[i], p);
        if (inj_p1 && p == 0 && i == 1) up_b[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
          if (p == 0) begin
            cnt_u[i][c] = 0;
            cnt_l[i][c] = 0;
          end
          cnt_u[i][c] += int'(up_b[c]);
          cnt_l[i][c] += int'(lo_b[c]);
        end
        if (emit) begin
          expq.push_back('{cyc: cyc + 3, addr: i,
            u: pack3(cnt_u[i][0], cnt_u[i][1], cnt_u[i][2]),
            l: pack3(cnt_l[i][0], cnt_l[i][1], cnt_l[i][2])});
        end
      end else begin
        up_b = 3'b111;
        lo_b = 3'b111;
      end
    end
    @(negedge clk);
    pix_valid  = 1'b0;
    frame_sync = 1'b1;
    image_sync = isync;
    @(negedge clk);
    frame_sync = 1'b0;
    image_sync = 1'b0;
  endtask

  task automatic run_cycle(input bit emit);
    for (int p = 0; p < 16; p++) send_frame(p, p == 15, emit && p == 15);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dec_valid"}, int'(dec_valid), 0);
    chk({tag, "_dec_addr"}, int'(dec_addr), 0);
    chk({tag, "_rgb_upper"}, int'(dec_rgb_upper), 0);
    chk({tag, "_rgb_lower"}, int'(dec_rgb_lower), 0);
    chk({tag, "_done"}, int'(dec_frame_done), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
    chk({tag, "_pix_err"}, int'(pix_err), 0);
  endtask

  task automatic check_image(input string tag, input int v0, input int d0);
    chk({tag, "_dv_count"}, dv_cnt - v0, N);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_done_after_last_dv"}, int'(done_cyc > last_dv), 1);
    chk({tag, "_pending"}, expq.size(), 0);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_up"}, int'(cap_up[i]), int'(col_up[i]));
      chk({tag, "_lo"}, int'(cap_lo[i]), int'(col_lo[i]));
    end
  endtask

  initial begin
    int v0;
    int d0;
    int s0;
    int e0;
    frame_sync = 1'b0;
    image_sync = 1'b0;
    pix_valid  = 1'b0;
    up_b       = 3'b000;
    lo_b       = 3'b000;
    rst        = 1'b0;
    #1 rst = 1'b1;

    tbl[0] = '0;
    tbl[0].up[0] = 12'hF3A;
    tbl[0].lo[3] = 12'h001;
    tbl[1] = '0;
    tbl[1].up[0] = 12'h123;
    tbl[1].lo[1] = 12'hFFF;
    tbl[1].up[2] = 12'h0F0;
    tbl[1].up[3] = 12'h800;
    for (int r = 2; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        tbl[r].up[i] = 12'($urandom);
        tbl[r].lo[i] = 12'($urandom);
      end
    end
    for (int r = 0; r < 5; r++) begin
      tbl[r].eu = tbl[r].up;
      tbl[r].el = tbl[r].lo;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin
      col_up[i] = 12'($urandom);
      col_lo[i] = 12'($urandom);
    end
    for (int f = 0; f < 40; f++) send_frame(f % 16, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("no_lock_dv_count", dv_cnt, 0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_cycle(1'b0);
    chk("prime_dv_count", dv_cnt, 0);
    chk("prime_done_count", done_cnt, 0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        col_up[i] = tbl[r].up[i];
        col_lo[i] = tbl[r].lo[i];
      end
      v0 = dv_cnt;
      d0 = done_cnt;
      run_cycle(1'b1);
      check_image("vec", v0, d0);
      for (int i = 0; i < N; i++) begin
        chk("tbl_up", int'(cap_up[i]), int'(tbl[r].eu[i]));
        chk("tbl_lo", int'(cap_lo[i]), int'(tbl[r].el[i]));
      end
    end

    for (int i = 0; i < N; i++) begin
      col_up[i] = 12'h000;
      col_lo[i] = 12'($urandom);
    end
    col_up[1] = 12'h005;
    inj_p1 = 1'b1;
    e0 = perr_cnt;
    run_cycle(1'b1);
    inj_p1 = 1'b0;
    chk("phase0_pix_err", perr_cnt - e0, 1);
    chk("phase0_px1_value", int'(cap_up[1]), 12'h006);

    for (int i = 0; i < N; i++) begin
      col_up[i] = 12'($urandom);
      col_lo[i] = 12'($urandom);
    end
    s0 = serr_cnt;
    v0 = dv_cnt;
    d0 = done_cnt;
    for (int p = 0; p < 6; p++) send_frame(p, p == 5, 1'b0);
    repeat (4) @(negedge clk);
    chk("misalign_sync_err", serr_cnt - s0, 1);
    chk("misalign_no_done", done_cnt - d0, 0);
    chk("misalign_no_dv", dv_cnt - v0, 0);

    ovf_phase = 3;
    e0 = perr_cnt;
    s0 = serr_cnt;
    v0 = dv_cnt;
    d0 = done_cnt;
    run_cycle(1'b1);
    ovf_phase = -1;
    chk("overflow_pix_err", perr_cnt - e0, 1);
    chk("recover_sync_err", serr_cnt - s0, 0);
    check_image("recover", v0, d0);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      up_b = 3'b101;
      lo_b = 3'b010;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    v0 = dv_cnt;
    d0 = done_cnt;
    run_cycle(1'b0);
    chk("unlocked_dv_count", dv_cnt - v0, 0);
    chk("unlocked_done_count", done_cnt - d0, 0);
    for (int i = 0; i < N; i++) begin
      col_up[i] = 12'($urandom);
      col_lo[i] = 12'($urandom);
    end
    v0 = dv_cnt;
    d0 = done_cnt;
    run_cycle(1'b1);
    check_image("relock", v0, d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
